// File: rtl/padded_buffer_writer_if.sv
// -----------------------------------------------------------------------------
// padded_buffer_writer_if
// Bundles the result-stream handshake and the padded-buffer write port of
// padded_buffer_writer.
//   in_data / in_valid / in_ready : result stream, one value per beat.
//       A beat transfers on a rising clock edge where in_valid & in_ready
//       are both high. in_valid may rise or fall freely; in_ready depends
//       only on the writer's state, never on in_valid.
//   wr_data / wr_addr / is_padding / wr_en : buffer write port, registered.
// Modports:
//   master : the result producer (drives the stream, observes the write port)
//   slave  : the writer itself
// -----------------------------------------------------------------------------
interface padded_buffer_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  is_padding;
  logic                  wr_en;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_data, wr_addr, is_padding, wr_en
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_data, wr_addr, is_padding, wr_en
  );
endinterface

// File: rtl/padded_buffer_writer.sv
// -----------------------------------------------------------------------------
// padded_buffer_writer
// Write-side controller for the zero-padded buffer feeding a 3x3 window reader.
// A frame is: zero every border cell (CLEAR), then place each incoming result
// value (raster pixel-major, channel-minor) at its padded address (STREAM),
// then pulse frame_done once the last write has committed.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a frame, sampled only in IDLE
//   bus        : stream handshake + buffer write port (slave modport)
//   busy       : high whenever the FSM is not in IDLE
//   frame_done : one-cycle pulse, the cycle after the final buffer write
//   dbg_state  : current FSM state (0 IDLE, 1 CLEAR, 2 STREAM, 3 DONE)
// Optional feature, macro PADDED_WRITER_CLEAR_ONCE_EN:
//   a sticky flag set at the end of the first CLEAR (cleared only by rst_n)
//   makes later starts skip CLEAR, since streaming never touches the border.
// -----------------------------------------------------------------------------
module padded_buffer_writer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_CHANNELS = 3,
  parameter int IN_WIDTH     = 5,
  parameter int IN_HEIGHT    = 5,
  parameter int PAD_WIDTH    = IN_WIDTH + 2,
  parameter int PAD_HEIGHT   = IN_HEIGHT + 2,
  parameter int DEPTH        = PAD_WIDTH * PAD_HEIGHT * OUT_CHANNELS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  padded_buffer_writer_if.slave  bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic [1:0]             dbg_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CH_W  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int COL_W = $clog2(PAD_WIDTH);
  localparam int ROW_W = $clog2(PAD_HEIGHT);

  // Address of padded (1,1), channel 0: first interior cell.
  localparam logic [AW-1:0] START_ADDR = AW'((PAD_WIDTH + 1) * OUT_CHANNELS);
  // CLEAR, middle rows: from (r,0,last ch) to (r,PAD_WIDTH-1,0).
  localparam logic [AW-1:0] SIDE_JUMP  = AW'((PAD_WIDTH - 2) * OUT_CHANNELS + 1);
  // STREAM: from the last interior cell of a row to the first of the next,
  // skipping the right border of this row and the left border of the next.
  localparam logic [AW-1:0] ROW_JUMP   = AW'(2 * OUT_CHANNELS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state_q;
  // Counters are shared: padded coordinates in CLEAR, interior ones in STREAM.
  logic [CH_W-1:0]       ch_q;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic [AW-1:0]         addr_q;       // running address of the next write
  logic                  wr_en_q;
  logic                  is_padding_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [AW-1:0]         wr_addr_q;
  logic                  frame_done_q;
  logic                  skip_clear;

`ifdef PADDED_WRITER_CLEAR_ONCE_EN
  logic cleared_q;
  assign skip_clear = cleared_q;
`else
  assign skip_clear = 1'b0;
`endif

  logic ch_last, clr_border_row, clr_last_col, clr_last_row;
  logic str_last_col, str_last_row;

  assign ch_last        = (ch_q == CH_W'(OUT_CHANNELS - 1));
  assign clr_last_col   = (col_q == COL_W'(PAD_WIDTH - 1));
  assign clr_last_row   = (row_q == ROW_W'(PAD_HEIGHT - 1));
  assign clr_border_row = (row_q == '0) || clr_last_row;
  assign str_last_col   = (col_q == COL_W'(IN_WIDTH - 1));
  assign str_last_row   = (row_q == ROW_W'(IN_HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      is_padding_q <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef PADDED_WRITER_CLEAR_ONCE_EN
      cleared_q    <= 1'b0;
`endif
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ch_q  <= '0;
            col_q <= '0;
            row_q <= '0;
            if (skip_clear) begin
              state_q <= S_STREAM;
              addr_q  <= START_ADDR;
            end else begin
              state_q <= S_CLEAR;
              addr_q  <= '0;
            end
          end
        end

        S_CLEAR: begin
          wr_en_q      <= 1'b1;
          is_padding_q <= 1'b1;
          wr_data_q    <= '0;
          wr_addr_q    <= addr_q;
          if (!ch_last) begin
            ch_q   <= ch_q + CH_W'(1);
            addr_q <= addr_q + AW'(1);
          end else begin
            ch_q <= '0;
            if (clr_last_row && clr_last_col) begin
              // Bottom-right corner done: hand over to streaming.
              state_q <= S_STREAM;
              col_q   <= '0;
              row_q   <= '0;
              addr_q  <= START_ADDR;
`ifdef PADDED_WRITER_CLEAR_ONCE_EN
              cleared_q <= 1'b1;
`endif
            end else if (clr_last_col) begin
              col_q  <= '0;
              row_q  <= row_q + ROW_W'(1);
              addr_q <= addr_q + AW'(1);
            end else if (clr_border_row) begin
              col_q  <= col_q + COL_W'(1);
              addr_q <= addr_q + AW'(1);
            end else begin
              // Middle row: only the two side cells are border.
              col_q  <= COL_W'(PAD_WIDTH - 1);
              addr_q <= addr_q + SIDE_JUMP;
            end
          end
        end

        S_STREAM: begin
          if (bus.in_valid) begin
            wr_en_q      <= 1'b1;
            is_padding_q <= 1'b0;
            wr_data_q    <= bus.in_data;
            wr_addr_q    <= addr_q;
            if (!ch_last) begin
              ch_q   <= ch_q + CH_W'(1);
              addr_q <= addr_q + AW'(1);
            end else begin
              ch_q <= '0;
              if (!str_last_col) begin
                col_q  <= col_q + COL_W'(1);
                addr_q <= addr_q + AW'(1);
              end else begin
                col_q <= '0;
                if (str_last_row) begin
                  state_q <= S_DONE;
                  row_q   <= '0;
                  addr_q  <= '0;
                end else begin
                  row_q  <= row_q + ROW_W'(1);
                  addr_q <= addr_q + ROW_JUMP;
                end
              end
            end
          end
        end

        S_DONE: begin
          // The last write is on the port during this cycle; the pulse lands
          // on the next one, after it has committed.
          frame_done_q <= 1'b1;
          state_q      <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == S_STREAM);
  assign bus.wr_en      = wr_en_q;
  assign bus.is_padding = is_padding_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_addr    = wr_addr_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = frame_done_q;
  assign dbg_state      = state_q;

endmodule
